// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM soft-start/soft-stop path:
// channel state encoding and the default duty-word width.
package motor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        RUN  = 2'd2,
        DOWN = 2'd3
    } ch_state_t;

    function automatic logic is_ramping(input ch_state_t s);
        return (s == UP) || (s == DOWN);
    endfunction

endpackage

// File: rtl/ramp_channel.sv
// One motor channel: duty register stepping one LSB per tick toward its goal,
// with the state classified each cycle from the stepped duty versus the goal.
module ramp_channel
    import motor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             req,
    input  logic             estop,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] duty,
    output ch_state_t        state,
    output ch_state_t        state_nxt
);

    logic [WIDTH-1:0] goal;
    logic [WIDTH-1:0] duty_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty  <= '0;
            state <= IDLE;
        end else begin
            duty  <= duty_nxt;
            state <= state_nxt;
        end
    end

    // estop forces goal and duty to zero, so classification falls to IDLE naturally
    always_comb begin
        goal     = (req && !estop) ? target : '0;
        duty_nxt = duty;
        if (estop) begin
            duty_nxt = '0;
        end else if (tick) begin
            if (duty < goal) begin
                duty_nxt = duty + 1'b1;
            end else if (duty > goal) begin
                duty_nxt = duty - 1'b1;
            end
        end

        if (duty_nxt < goal) begin
            state_nxt = UP;
        end else if (duty_nxt > goal) begin
            state_nxt = DOWN;
        end else if (goal == '0) begin
            state_nxt = IDLE;
        end else begin
            state_nxt = RUN;
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Two-channel soft-start/soft-stop sequencer: period-boundary detect and a shared
// step prescaler feeding two ramp_channel instances.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned RAMP_PERIODS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] trigger,
    input  logic             req_left,
    input  logic             req_right,
    input  logic [WIDTH-1:0] target,
    input  logic             estop,
    output logic [WIDTH-1:0] lcontrol,
    output logic [WIDTH-1:0] rcontrol,
    output logic [1:0]       lstate,
    output logic [1:0]       rstate,
    output logic             busy
);

    localparam int unsigned PW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_PERIODS - 1);

    logic          strobe;
    logic          tick;
    logic [PW-1:0] presc;
    ch_state_t     lst, rst_state;
    ch_state_t     lst_nxt, rst_nxt;

    // Tick on the last trigger count so the new duty lands as the counter wraps to 0
    assign strobe = (trigger == '1);
    assign tick   = strobe && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            busy  <= 1'b0;
        end else begin
            if (strobe) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            busy <= is_ramping(lst_nxt) || is_ramping(rst_nxt);
        end
    end

    ramp_channel #(.WIDTH(WIDTH)) u_left (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req       (req_left),
        .estop     (estop),
        .target    (target),
        .duty      (lcontrol),
        .state     (lst),
        .state_nxt (lst_nxt)
    );

    ramp_channel #(.WIDTH(WIDTH)) u_right (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req       (req_right),
        .estop     (estop),
        .target    (target),
        .duty      (rcontrol),
        .state     (rst_state),
        .state_nxt (rst_nxt)
    );

    assign lstate = lst;
    assign rstate = rst_state;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl: two instances (RAMP_PERIODS 2 and 1) checked
// every cycle against a behavioural model through a scoreboard queue.
module tb_motor_ramp_ctrl;
    import motor_pkg::*;

    typedef struct packed {
        logic [2:0] l;
        logic [2:0] r;
        logic [1:0] ls;
        logic [1:0] rs;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] trig;

    logic       a_req_l, a_req_r, a_es;
    logic [2:0] a_tg;
    logic [2:0] a_l, a_r;
    logic [1:0] a_ls, a_rs;
    logic       a_busy;

    logic       b_req_l, b_req_r, b_es;
    logic [2:0] b_tg;
    logic [2:0] b_l, b_r;
    logic [1:0] b_ls, b_rs;
    logic       b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    int ma_p, ma_dl, ma_dr, ma_sl, ma_sr;
    int mb_p, mb_dl, mb_dr, mb_sl, mb_sr;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    motor_ramp_ctrl #(.WIDTH(3), .RAMP_PERIODS(2)) dut_a (
        .clk(clk), .rst(rst), .trigger(trig),
        .req_left(a_req_l), .req_right(a_req_r), .target(a_tg), .estop(a_es),
        .lcontrol(a_l), .rcontrol(a_r), .lstate(a_ls), .rstate(a_rs), .busy(a_busy)
    );

    motor_ramp_ctrl #(.WIDTH(3), .RAMP_PERIODS(1)) dut_b (
        .clk(clk), .rst(rst), .trigger(trig),
        .req_left(b_req_l), .req_right(b_req_r), .target(b_tg), .estop(b_es),
        .lcontrol(b_l), .rcontrol(b_r), .lstate(b_ls), .rstate(b_rs), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chan(input bit tick, input bit req, input bit es, input int tg,
                        inout int d, output int s);
        int goal;
        goal = (req && !es) ? tg : 0;
        if (es) begin
            d = 0;
        end else if (tick && d != goal) begin
            d = (d < goal) ? d + 1 : d - 1;
        end
        if (d == goal) s = (goal == 0) ? 0 : 2;
        else           s = (d < goal) ? 1 : 3;
    endtask

    task automatic model(input int rp, input bit rs, input bit rl, input bit rr, input bit es,
                         input int tg, input int trg,
                         inout int presc, inout int dl, inout int dr, inout int sl, inout int sr,
                         output exp_t e);
        bit tick;
        tick = 1'b0;
        if (rs) begin
            presc = 0; dl = 0; dr = 0; sl = 0; sr = 0;
        end else begin
            if (trg == 7) begin
                tick  = (presc == rp - 1);
                presc = tick ? 0 : presc + 1;
            end
            chan(tick, rl, es, tg, dl, sl);
            chan(tick, rr, es, tg, dr, sr);
        end
        e.l    = 3'(dl);
        e.r    = 3'(dr);
        e.ls   = 2'(sl);
        e.rs   = 2'(sr);
        e.busy = (sl == 1 || sl == 3 || sr == 1 || sr == 3);
    endtask

    task automatic step();
        exp_t ea, eb;
        logic [2:0] pal, par, pbr;
        bit boundary_ok;
        model(2, rst, a_req_l, a_req_r, a_es, int'(a_tg), int'(trig),
              ma_p, ma_dl, ma_dr, ma_sl, ma_sr, ea);
        qa.push_back(ea);
        model(1, rst, b_req_l, b_req_r, b_es, int'(b_tg), int'(trig),
              mb_p, mb_dl, mb_dr, mb_sl, mb_sr, eb);
        qb.push_back(eb);
        pal = a_l; par = a_r; pbr = b_r;
        boundary_ok = !rst && !a_es;
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("a_lcontrol", a_l, ea.l);
        check("a_rcontrol", a_r, ea.r);
        check("a_lstate", a_ls, ea.ls);
        check("a_rstate", a_rs, ea.rs);
        check("a_busy", a_busy, ea.busy);
        check("b_lcontrol", b_l, eb.l);
        check("b_rcontrol", b_r, eb.r);
        check("b_lstate", b_ls, eb.ls);
        check("b_rstate", b_rs, eb.rs);
        check("b_busy", b_busy, eb.busy);
        // any duty change outside reset/estop must follow the trigger==7 cycle
        if (boundary_ok && a_l !== pal) check("a_l_boundary", trig, 7);
        if (boundary_ok && a_r !== par) check("a_r_boundary", trig, 7);
        if (!rst && b_r !== pbr)        check("b_r_boundary", trig, 7);
        trig = trig + 3'd1;
    endtask

    task automatic wait_a(input string tag, input int l, input int r, input int ls, input int rs);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step();
            hit = (a_l == 3'(l)) && (a_r == 3'(r)) && (a_ls == 2'(ls)) && (a_rs == 2'(rs));
        end
        check(tag, 8'(hit), 8'd1);
    endtask

    task automatic wait_b(input string tag, input int r, input int rs);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            hit = (b_r == 3'(r)) && (b_rs == 2'(rs));
        end
        check(tag, 8'(hit), 8'd1);
    endtask

    initial begin
        rst = 1'b1; trig = 3'd0;
        a_req_l = 1'b0; a_req_r = 1'b0; a_es = 1'b0; a_tg = 3'd0;
        b_req_l = 1'b0; b_req_r = 1'b0; b_es = 1'b0; b_tg = 3'd0;
        ma_p = 0; ma_dl = 0; ma_dr = 0; ma_sl = 0; ma_sr = 0;
        mb_p = 0; mb_dl = 0; mb_dr = 0; mb_sl = 0; mb_sr = 0;

        step();
        step();
        check("rst_lcontrol", a_l, 0);
        check("rst_lstate", a_ls, IDLE);
        check("rst_busy", a_busy, 0);
        rst = 1'b0;

        // ramp up 0 -> 5 on the left channel
        a_req_l = 1'b1; a_tg = 3'd5;
        step();
        check("up_state", a_ls, UP);
        check("up_busy", a_busy, 1);
        wait_a("ramp_to_5", 5, 0, RUN, IDLE);
        check("run_busy", a_busy, 0);

        // drop request -> ramp down to IDLE
        a_req_l = 1'b0;
        step();
        check("down_state", a_ls, DOWN);
        wait_a("ramp_to_0", 0, 0, IDLE, IDLE);

        // target changes while running
        a_req_l = 1'b1; a_tg = 3'd5;
        wait_a("ramp_to_5b", 5, 0, RUN, IDLE);
        a_tg = 3'd2;
        step();
        check("tgt_down_state", a_ls, DOWN);
        wait_a("ramp_to_2", 2, 0, RUN, IDLE);
        a_tg = 3'd7;
        step();
        check("tgt_up_state", a_ls, UP);
        wait_a("ramp_to_7", 7, 0, RUN, IDLE);

        // reset mid ramp-down
        a_tg = 3'd2;
        wait_a("down_to_4", 4, 0, DOWN, IDLE);
        rst = 1'b1;
        step();
        check("midrst_lcontrol", a_l, 0);
        check("midrst_lstate", a_ls, IDLE);
        check("midrst_busy", a_busy, 0);
        rst = 1'b0;
        a_req_l = 1'b0;
        repeat (40) step();

        // both channels ramp together, estop mid-ramp
        a_req_l = 1'b1; a_req_r = 1'b1; a_tg = 3'd7;
        wait_a("both_to_3", 3, 3, UP, UP);
        a_es = 1'b1;
        step();
        check("estop_l", a_l, 0);
        check("estop_r", a_r, 0);
        check("estop_ls", a_ls, IDLE);
        check("estop_rs", a_rs, IDLE);
        check("estop_busy", a_busy, 0);
        repeat (20) step();
        check("estop_hold_l", a_l, 0);
        a_es = 1'b0;
        wait_a("both_to_7", 7, 7, RUN, RUN);

        // RAMP_PERIODS=1 instance: zero target stays idle, then one step per boundary
        b_req_r = 1'b1; b_tg = 3'd0;
        repeat (20) step();
        check("b_zero_state", b_rs, IDLE);
        check("b_zero_duty", b_r, 0);
        b_tg = 3'd1;
        wait_b("b_to_1", 1, RUN);
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
